// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage signal bundle shared by the control/datapath side (master) and
// fetch_pc_unit (slave).
interface fetch_pc_unit_if #(
  parameter int PC_W = 64
);
  logic            stall;
  logic [31:0]     instruction;
  logic            UBranch;
  logic            Branch;
  logic            alu_zero;
  logic            alu_negative;
  logic            alu_carry;
  logic            alu_overflow;
  logic [PC_W-1:0] pc;
  logic [10:0]     opcode;
  logic            flag_n;
  logic            flag_z;
  logic            flag_c;
  logic            flag_v;
  logic            branch_taken;

  modport master (
    output stall, instruction, UBranch, Branch,
           alu_zero, alu_negative, alu_carry, alu_overflow,
    input  pc, opcode, flag_n, flag_z, flag_c, flag_v, branch_taken
  );

  modport slave (
    input  stall, instruction, UBranch, Branch,
           alu_zero, alu_negative, alu_carry, alu_overflow,
    output pc, opcode, flag_n, flag_z, flag_c, flag_v, branch_taken
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// LEGv8 fetch stage: program counter, next-PC resolution for B/CBZ/B.LT and
// the architectural NZCV flags register written by ADDS/SUBS.
module fetch_pc_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             reset,
  fetch_pc_unit_if.slave  bus
);

  localparam logic [7:0]  CBZ_OP   = 8'b1011_0100;
  localparam logic [7:0]  BCOND_OP = 8'b0101_0100;
  localparam logic [4:0]  COND_LT  = 5'b01011;
  localparam logic [10:0] OP_ADDS  = 11'b101_0101_1000;
  localparam logic [10:0] OP_SUBS  = 11'b111_0101_1000;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  logic [PC_W-1:0] pc_q, pc_d;
  nzcv_t           flags_q, flags_d;

  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] cond_off;
  logic            is_cbz;
  logic            is_bcond_lt;
  logic            cond_taken;
  logic            set_flags;

  // Decode and immediates
  assign bus.opcode = bus.instruction[31:21];

  assign br_off   = {{(PC_W-28){bus.instruction[25]}}, bus.instruction[25:0], 2'b00};
  assign cond_off = {{(PC_W-21){bus.instruction[23]}}, bus.instruction[23:5], 2'b00};

  assign is_cbz      = (bus.instruction[31:24] == CBZ_OP);
  assign is_bcond_lt = (bus.instruction[31:24] == BCOND_OP) &&
                       (bus.instruction[4:0] == COND_LT);

  // B.LT uses the registered flags, so a flag-setting instruction is seen by
  // the branch that follows it, never by itself.
  assign cond_taken = bus.Branch &&
                      ((is_cbz && bus.alu_zero) ||
                       (is_bcond_lt && (flags_q.n != flags_q.v)));

  assign set_flags = (bus.opcode == OP_ADDS) || (bus.opcode == OP_SUBS);

  assign bus.branch_taken = bus.UBranch || cond_taken;

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pc_d    = pc_q + PC_W'(4);
    flags_d = flags_q;

    if (bus.UBranch) begin
      pc_d = pc_q + br_off;
    end else if (cond_taken) begin
      pc_d = pc_q + cond_off;
    end

    if (set_flags) begin
      flags_d = '{n: bus.alu_negative, z: bus.alu_zero,
                  c: bus.alu_carry,    v: bus.alu_overflow};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      pc_q    <= RESET_PC;
      flags_q <= '0;
    end else if (!bus.stall) begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.flag_n = flags_q.n;
  assign bus.flag_z = flags_q.z;
  assign bus.flag_c = flags_q.c;
  assign bus.flag_v = flags_q.v;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table followed by
// random legal instruction streams checked against an arithmetic PC/flag model.
module tb_fetch_pc_unit;

  localparam int PC_W = 64;

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic [31:0] ins;
    logic        ub;
    logic        br;
    logic [3:0]  alu;        // {N,Z,C,V}
    logic        exp_taken;
    logic [63:0] exp_pc;
    logic [3:0]  exp_flags;  // {N,Z,C,V}
  } vec_t;

  localparam logic [31:0] ADDI = 32'h9100_0421;
  localparam logic [31:0] SUBS = 32'hEB02_0020;
  localparam logic [31:0] ADDS = 32'hAB02_0020;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit_if #(.PC_W(PC_W)) bus ();

  fetch_pc_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] b_ins(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  function automatic logic [31:0] cbz_ins(input logic [18:0] imm);
    return {8'hB4, imm, 5'd3};
  endfunction

  function automatic logic [31:0] bcond_ins(input logic [18:0] imm, input logic [4:0] cond);
    return {8'h54, imm, cond};
  endfunction

  function automatic vec_t mk(input logic rst, input logic stl, input logic [31:0] ins,
                              input logic ub, input logic br, input logic [3:0] alu,
                              input logic t, input logic [63:0] p, input logic [3:0] f);
    vec_t v;
    v = '{rst: rst, stl: stl, ins: ins, ub: ub, br: br, alu: alu,
          exp_taken: t, exp_pc: p, exp_flags: f};
    return v;
  endfunction

  // Two's-complement value of a 'bits'-wide field, as a plain signed number.
  function automatic longint as_signed(input longint raw, input int bits);
    if (raw >= (longint'(1) <<< (bits - 1))) return raw - (longint'(1) <<< bits);
    return raw;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a point where clk is low; drives, checks combinational outputs,
  // crosses one rising edge, checks state, then returns at the next falling edge.
  task automatic apply(input vec_t v, input string tag);
    reset            = v.rst;
    bus.stall        = v.stl;
    bus.instruction  = v.ins;
    bus.UBranch      = v.ub;
    bus.Branch       = v.br;
    bus.alu_negative = v.alu[3];
    bus.alu_zero     = v.alu[2];
    bus.alu_carry    = v.alu[1];
    bus.alu_overflow = v.alu[0];
    #1;
    check({tag, " taken"}, 64'(bus.branch_taken), 64'(v.exp_taken));
    check({tag, " opcode"}, 64'(bus.opcode), 64'(v.ins[31:21]));
    @(posedge clk);
    #1;
    check({tag, " pc"}, bus.pc, v.exp_pc);
    check({tag, " flags"}, 64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}),
          64'(v.exp_flags));
    @(negedge clk);
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [63:0] pc_m;
    logic [3:0]  fl_m;
    logic [31:0] ins;
    logic [3:0]  nzcv;
    logic [4:0]  cond;
    logic        rst, stl, ub, br, taken;
    longint      off;
    int          kind;

    // Directed sequence; each row's expected pc is the value after its edge.
    vecs.push_back(mk(1, 0, ADDI, 0, 0, 4'b0000, 0, 64'h00, 4'b0000));
    vecs.push_back(mk(0, 0, ADDI, 0, 0, 4'b1111, 0, 64'h04, 4'b0000));
    vecs.push_back(mk(0, 0, ADDI, 0, 0, 4'b1111, 0, 64'h08, 4'b0000));
    vecs.push_back(mk(0, 0, ADDI, 0, 0, 4'b0000, 0, 64'h0C, 4'b0000));
    vecs.push_back(mk(0, 0, ADDI, 0, 0, 4'b0000, 0, 64'h10, 4'b0000));
    vecs.push_back(mk(0, 0, b_ins(26'h3FF_FFFE), 1, 0, 4'b0000, 1, 64'h08, 4'b0000));
    vecs.push_back(mk(0, 0, ADDI, 0, 0, 4'b0000, 0, 64'h0C, 4'b0000));
    vecs.push_back(mk(0, 0, ADDI, 0, 0, 4'b0000, 0, 64'h10, 4'b0000));
    vecs.push_back(mk(0, 0, b_ins(26'h000_0010), 1, 0, 4'b0000, 1, 64'h50, 4'b0000));
    vecs.push_back(mk(0, 0, b_ins(26'h3FF_FFF4), 1, 0, 4'b0000, 1, 64'h20, 4'b0000));
    vecs.push_back(mk(0, 0, cbz_ins(19'd3), 0, 1, 4'b0100, 1, 64'h2C, 4'b0000));
    vecs.push_back(mk(0, 0, b_ins(26'h3FF_FFFD), 1, 0, 4'b0000, 1, 64'h20, 4'b0000));
    vecs.push_back(mk(0, 0, cbz_ins(19'd3), 0, 1, 4'b0000, 0, 64'h24, 4'b0000));
    vecs.push_back(mk(0, 0, SUBS, 0, 0, 4'b1000, 0, 64'h28, 4'b1000));
    vecs.push_back(mk(0, 0, bcond_ins(19'd4, 5'b01011), 0, 1, 4'b0000, 1, 64'h38, 4'b1000));
    vecs.push_back(mk(0, 0, SUBS, 0, 0, 4'b1001, 0, 64'h3C, 4'b1001));
    // Live ALU says N!=V here, registered flags say N==V: must not branch.
    vecs.push_back(mk(0, 0, bcond_ins(19'd4, 5'b01011), 0, 1, 4'b1000, 0, 64'h40, 4'b1001));
    vecs.push_back(mk(0, 1, SUBS, 0, 0, 4'b0000, 0, 64'h40, 4'b1001));
    vecs.push_back(mk(0, 1, SUBS, 0, 0, 4'b0000, 0, 64'h40, 4'b1001));
    vecs.push_back(mk(0, 1, b_ins(26'h000_0004), 1, 0, 4'b0000, 1, 64'h40, 4'b1001));
    vecs.push_back(mk(1, 1, SUBS, 0, 0, 4'b0110, 0, 64'h00, 4'b0000));
    vecs.push_back(mk(0, 0, SUBS, 0, 0, 4'b0001, 0, 64'h04, 4'b0001));
    vecs.push_back(mk(0, 0, bcond_ins(19'h7FFFF, 5'b01011), 0, 1, 4'b0000, 1, 64'h00, 4'b0001));
    vecs.push_back(mk(0, 0, bcond_ins(19'd4, 5'b00000), 0, 1, 4'b0000, 0, 64'h04, 4'b0001));
    vecs.push_back(mk(1, 0, b_ins(26'h000_0004), 1, 0, 4'b0000, 1, 64'h00, 4'b0000));
    vecs.push_back(mk(0, 0, b_ins(26'h3FF_FFFF), 1, 0, 4'b0000, 1, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0000));
    vecs.push_back(mk(0, 0, ADDI, 0, 0, 4'b0000, 0, 64'h00, 4'b0000));
    vecs.push_back(mk(0, 0, b_ins(26'h3FF_FFFF), 1, 0, 4'b0000, 1, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0000));
    vecs.push_back(mk(0, 0, b_ins(26'h000_0001), 1, 0, 4'b0000, 1, 64'h00, 4'b0000));
    vecs.push_back(mk(0, 0, ADDS, 0, 0, 4'b0110, 0, 64'h04, 4'b0110));
    vecs.push_back(mk(0, 0, ADDI, 0, 0, 4'b1001, 0, 64'h08, 4'b0110));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Random legal instruction stream against the reference model.
    pc_m = 64'h08;
    fl_m = 4'b0110;
    for (int i = 0; i < 1500; i++) begin
      kind  = $urandom_range(0, 5);
      rst   = ($urandom_range(0, 63) == 0);
      stl   = ($urandom_range(0, 7) == 0);
      nzcv  = 4'($urandom);
      ub    = 1'b0;
      br    = 1'b0;
      taken = 1'b0;
      off   = 4;
      case (kind)
        0: ins = 32'h9100_0000 | ($urandom & 32'h003F_FFFF);
        1: ins = 32'hAB00_0000 | ($urandom & 32'h001F_FFFF);
        2: ins = 32'hEB00_0000 | ($urandom & 32'h001F_FFFF);
        3: begin
          ins   = b_ins(26'($urandom));
          ub    = 1'b1;
          taken = 1'b1;
          off   = 4 * as_signed(longint'(ins & 32'h03FF_FFFF), 26);
        end
        4: begin
          ins   = cbz_ins(19'($urandom));
          br    = 1'b1;
          taken = nzcv[2];
          if (taken) off = 4 * as_signed(longint'((ins >> 5) & 32'h7FFFF), 19);
        end
        default: begin
          cond  = ($urandom_range(0, 1) == 1) ? 5'b01011 : 5'($urandom_range(0, 15));
          ins   = bcond_ins(19'($urandom), cond);
          br    = 1'b1;
          taken = (cond == 5'b01011) && (fl_m[3] != fl_m[0]);
          if (taken) off = 4 * as_signed(longint'((ins >> 5) & 32'h7FFFF), 19);
        end
      endcase

      if (rst) begin
        pc_m = 64'h0;
        fl_m = 4'b0000;
      end else if (!stl) begin
        pc_m = pc_m + 64'(off);
        if (kind == 1 || kind == 2) fl_m = nzcv;
      end

      v = mk(rst, stl, ins, ub, br, nzcv, taken, pc_m, fl_m);
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Upstream fetch stage of the single-cycle LEGv8 CPU.
- Holds the program counter and presents the fetch address to instruction memory. Slices the 11-bit opcode that feeds the control unit.
- Resolves next-PC from the control unit's UBranch/Branch outputs plus ALU status. Owns the architectural NZCV flags register, which is updated by ADDS/SUBS and consumed by B.LT.

Parameters:
- PC_W, 64, program counter / address width in bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; overrides all other inputs
- stall  input  1  1 = hold PC and flags this cycle
- instruction  input  32  instruction word read combinationally from imem at address pc
- UBranch  input  1  unconditional-branch control from control unit
- Branch  input  1  conditional-branch control from control unit (CBZ or B.LT)
- alu_zero  input  1  ALU zero result of current instruction
- alu_negative  input  1  ALU N result
- alu_carry  input  1  ALU C result
- alu_overflow  input  1  ALU V result
- pc  output  PC_W  current fetch address
- opcode  output  11  instruction[31:21], to control unit
- flag_n, flag_z, flag_c, flag_v  output  1 each  registered NZCV
- branch_taken  output  1  combinational: next PC is a branch target

Behaviour:
- Reset (sync): pc <= RESET_PC; all flags <= 0. branch_taken follows combinationally from the inputs and the reset register values.
- opcode = instruction[31:21]; purely combinational, zero latency.
- Immediates:
  - br_off = sign-extend(instruction[25:0]) << 2.
  - cond_off = sign-extend(instruction[23:5]) << 2.
  - Both are extended to PC_W.
- Branch classification uses instruction[31:24]:
  - 10110100 = CBZ: taken when Branch=1 and alu_zero=1.
  - 01010100 = B.cond: taken when Branch=1, instruction[4:0]=01011 (LT), and flag_n != flag_v. B.LT reads the REGISTERED flags, i.e. flags set by an earlier instruction, never the same-cycle ALU outputs.
  - Any other cond code, or Branch=1 with an unrecognised [31:24]: not taken.
- UBranch=1: taken, target = pc + br_off. UBranch has priority if both UBranch and Branch are 1.
- Next PC:
  - Taken conditional: pc + cond_off.
  - Taken unconditional: pc + br_off.
  - Otherwise: pc + 4.
  - All arithmetic is modulo 2^PC_W; wrap-around is silent, no trap.
- Flag set: set_flags is decoded internally as opcode == 10101011000 (ADDS) or 11101011000 (SUBS). When set_flags=1 and stall=0, {flag_n,flag_z,flag_c,flag_v} <= {alu_negative,alu_zero,alu_carry,alu_overflow} at the edge. Other instructions leave flags unchanged.
- A flag-setting instruction followed immediately by B.LT: B.LT sees the new flags (one-edge latency).
- Stall=1: pc and flags hold. branch_taken is still driven combinationally. A branch decision is re-evaluated each stalled cycle.
- Reset asserted mid-program, including while stalled or on a taken branch: reset wins. pc = RESET_PC after the edge.
- Only control-unit-decoded opcodes are legal. The bench must not present the control unit's default (X) outputs.

Test Plan:
- Reset then 3 cycles of ADDI (0x91000421), Branch=UBranch=0 -> pc sequence 0,4,8,12; flags stay 0000.
- At pc=0x10, B with imm26=0x3FFFFFE (−2), UBranch=1 -> branch_taken=1, next pc=0x08. Imm26=0x0000010 -> next pc=0x50.
- CBZ at pc=0x20, imm19=3, Branch=1: alu_zero=1 -> pc=0x2C; alu_zero=0 -> pc=0x24.
- SUBS with alu N=1,Z=0,C=0,V=0 at cycle k, then B.LT (cond 01011, imm19=4) at k+1 -> flags 1000 after edge k, B.LT taken. Repeat with V=1 -> not taken, pc+4.
- stall=1 for 2 cycles during SUBS -> pc and flags unchanged. reset=1 with stall=1 and pc=0x40 -> pc=0, flags=0000.
- pc=0xFFFFFFFFFFFFFFFC, no branch -> pc wraps to 0; B with imm26=1 -> pc=0.
